// File: rtl/acq_dump_detector.sv
// Prompt-accumulator consumer: epoch timing, |I|+|Q| dump and N-of-M acquisition search.
// Steps the code phase on failed dwells and declares or drops lock on the chosen bin.
module acq_dump_detector #(
  parameter int ACC_W     = 20,
  parameter int EPOCH_CNT = 16368,
  parameter int M_DWELL   = 4,
  parameter int N_HIT     = 3,
  parameter int LOSS_CNT  = 3,
  parameter int MAX_PHASE = 2046
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] i_acc,
  input  logic [ACC_W-1:0] q_acc,
  input  logic [ACC_W:0]   threshold,
  output logic             accclr,
  output logic             dump_valid,
  output logic [ACC_W:0]   mag,
  output logic             slip_req,
  output logic [10:0]      code_phase,
  output logic             acq_lock,
  output logic             search_fail
);

  localparam int EW = (EPOCH_CNT > 1) ? $clog2(EPOCH_CNT) : 1;
  localparam int DW = $clog2(M_DWELL + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);

  localparam logic [EW-1:0] EP_LAST    = EW'(EPOCH_CNT - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(M_DWELL - 1);
  localparam logic [DW-1:0] HIT_NEED   = DW'(N_HIT);
  localparam logic [MW-1:0] LOSS_LAST  = MW'(LOSS_CNT - 1);
  localparam logic [10:0]   PHASE_LAST = 11'(MAX_PHASE - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DWELL  = 2'd1;
  localparam logic [1:0] SLIP   = 2'd2;
  localparam logic [1:0] LOCKED = 2'd3;

  logic [1:0]       state;
  logic [EW-1:0]    ep_cnt;
  logic [ACC_W-1:0] cap_i;
  logic [ACC_W-1:0] cap_q;
  logic             cap_pending;
  logic [DW-1:0]    dwell_cnt;
  logic [DW-1:0]    hit_cnt;
  logic [MW-1:0]    miss_cnt;

  logic             epoch_end;
  logic             fire;
  logic             hit;
  logic [DW-1:0]    hit_cnt_nx;
  logic [ACC_W-1:0] abs_i;
  logic [ACC_W-1:0] abs_q;
  logic [ACC_W:0]   mag_nx;

  // The most negative input negates to itself, which read as unsigned is exactly 2^(ACC_W-1).
  always_comb begin
    epoch_end  = (state != IDLE) && (ep_cnt == EP_LAST);
    fire       = en && epoch_end;
    hit        = (mag >= threshold);
    hit_cnt_nx = hit_cnt + DW'(hit);
    abs_i      = cap_i[ACC_W-1] ? (~cap_i) + ACC_W'(1) : cap_i;
    abs_q      = cap_q[ACC_W-1] ? (~cap_q) + ACC_W'(1) : cap_q;
    mag_nx     = {1'b0, abs_i} + {1'b0, abs_q};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state       <= IDLE;
      ep_cnt      <= '0;
      cap_i       <= '0;
      cap_q       <= '0;
      cap_pending <= 1'b0;
      dwell_cnt   <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      accclr      <= 1'b0;
      dump_valid  <= 1'b0;
      mag         <= '0;
      slip_req    <= 1'b0;
      code_phase  <= '0;
      acq_lock    <= 1'b0;
      search_fail <= 1'b0;
    end else begin
      dump_valid  <= 1'b0;
      slip_req    <= 1'b0;
      search_fail <= 1'b0;
      accclr      <= fire;
      // Dropping enable overrides any capture, dump or slip decided on the same edge.
      if (!en) begin
        state       <= IDLE;
        ep_cnt      <= '0;
        cap_pending <= 1'b0;
        dwell_cnt   <= '0;
        hit_cnt     <= '0;
        miss_cnt    <= '0;
        acq_lock    <= 1'b0;
        accclr      <= 1'b1;
      end else begin
        cap_pending <= fire;
        if (fire) begin
          cap_i <= i_acc;
          cap_q <= q_acc;
        end
        if (cap_pending) begin
          mag        <= mag_nx;
          dump_valid <= 1'b1;
        end
        if (state != IDLE)
          ep_cnt <= epoch_end ? '0 : ep_cnt + EW'(1);

        case (state)
          IDLE: state <= DWELL;
          DWELL: begin
            if (dump_valid) begin
              if (dwell_cnt == DWELL_LAST) begin
                dwell_cnt <= '0;
                hit_cnt   <= '0;
                if (hit_cnt_nx >= HIT_NEED) begin
                  state    <= LOCKED;
                  acq_lock <= 1'b1;
                  miss_cnt <= '0;
                end else begin
                  state       <= SLIP;
                  slip_req    <= 1'b1;
                  code_phase  <= (code_phase == PHASE_LAST) ? 11'd0 : code_phase + 11'd1;
                  search_fail <= (code_phase == PHASE_LAST);
                end
              end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
                hit_cnt   <= hit_cnt_nx;
              end
            end
          end
          SLIP: state <= DWELL;
          LOCKED: begin
            // Losing lock re-dwells the same bin rather than slipping.
            if (dump_valid) begin
              if (hit) begin
                miss_cnt <= '0;
              end else if (miss_cnt == LOSS_LAST) begin
                state     <= DWELL;
                acq_lock  <= 1'b0;
                miss_cnt  <= '0;
                dwell_cnt <= '0;
                hit_cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + MW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acq_dump_detector.sv
// Directed bench for acq_dump_detector with small epoch and phase range.
// Expected magnitudes are queued at stimulus time and popped when dump_valid appears.
module tb_acq_dump_detector;

  logic        clk;
  logic        clr;
  logic        en;
  logic [19:0] i_acc;
  logic [19:0] q_acc;
  logic [20:0] threshold;
  logic        accclr;
  logic        dump_valid;
  logic [20:0] mag;
  logic        slip_req;
  logic [10:0] code_phase;
  logic        acq_lock;
  logic        search_fail;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int ref_cyc = 0;
  int have_ref = 0;
  int slip_cnt = 0;
  int exp_q[$];
  logic prev_dv = 1'b0;
  logic prev_slip = 1'b0;
  logic prev_sf = 1'b0;

  acq_dump_detector #(
    .ACC_W(20), .EPOCH_CNT(8), .M_DWELL(4), .N_HIT(3), .LOSS_CNT(3), .MAX_PHASE(4)
  ) dut (
    .clk(clk), .clr(clr), .en(en), .i_acc(i_acc), .q_acc(q_acc), .threshold(threshold),
    .accclr(accclr), .dump_valid(dump_valid), .mag(mag), .slip_req(slip_req),
    .code_phase(code_phase), .acq_lock(acq_lock), .search_fail(search_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic int model_mag(input int i, input int q);
    int a;
    int b;
    a = (i < 0) ? -i : i;
    b = (q < 0) ? -q : q;
    return a + b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one epoch's accumulator values, then follows it through capture and dump.
  task automatic applyStimulus(input int i, input int q);
    int n;
    i_acc = i[19:0];
    q_acc = q[19:0];
    exp_q.push_back(model_mag(i, q));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (accclr !== 1'b1 && n < 40);
    checkOutput("accclr_seen", 32'(accclr), 32'd1);
    if (have_ref != 0) checkOutput("epoch_len", cyc - ref_cyc, 32'd8);
    ref_cyc = cyc;
    have_ref = 1;
    @(negedge clk);
    checkOutput("dump_after_accclr", 32'(dump_valid), 32'd1);
  endtask

  task automatic checkDecision(input logic slip, input int phase, input logic sf, input logic lock);
    @(negedge clk);
    checkOutput("slip_req", 32'(slip_req), 32'(slip));
    checkOutput("code_phase", 32'(code_phase), phase);
    checkOutput("search_fail", 32'(search_fail), 32'(sf));
    checkOutput("acq_lock", 32'(acq_lock), 32'(lock));
  endtask

  // Scoreboard and strobe-width monitor.
  always @(negedge clk) begin
    int e;
    if (dump_valid === 1'b1) begin
      if (exp_q.size() == 0) checkOutput("unexpected_dump", 32'(dump_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        checkOutput("mag", 32'(mag), e);
      end
    end
    if (prev_dv) checkOutput("dv_width", 32'(dump_valid), 32'd0);
    if (prev_slip) checkOutput("slip_width", 32'(slip_req), 32'd0);
    if (prev_sf) checkOutput("sf_width", 32'(search_fail), 32'd0);
    if (slip_req === 1'b1) slip_cnt++;
    prev_dv = dump_valid;
    prev_slip = slip_req;
    prev_sf = search_fail;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    clr = 1'b0;
    en = 1'b0;
    threshold = 21'd100;
    i_acc = '0;
    q_acc = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_accclr", 32'(accclr), 32'd0);
    checkOutput("rst_dv", 32'(dump_valid), 32'd0);
    checkOutput("rst_mag", 32'(mag), 32'd0);
    checkOutput("rst_slip", 32'(slip_req), 32'd0);
    checkOutput("rst_phase", 32'(code_phase), 32'd0);
    checkOutput("rst_lock", 32'(acq_lock), 32'd0);
    checkOutput("rst_sf", 32'(search_fail), 32'd0);

    clr = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_accclr", 32'(accclr), 32'd1);

    // Phase 0: one big hit among small misses is not enough, so the bin slips.
    en = 1'b1;
    ref_cyc = cyc + 1;
    have_ref = 1;
    applyStimulus(-5, 7);
    applyStimulus(-524288, -524288);
    applyStimulus(-5, 7);
    applyStimulus(-5, 7);
    checkDecision(1'b1, 1, 1'b0, 1'b0);

    // Weak signal everywhere: walk phases 1..3 and wrap to 0 with search_fail.
    for (int p = 2; p <= 4; p++) begin
      repeat (4) applyStimulus(20, -30);
      checkDecision(1'b1, p % 4, (p == 4), 1'b0);
    end

    // Three hits out of four at phase 0 declare lock.
    applyStimulus(100, -50);
    applyStimulus(100, -50);
    applyStimulus(20, -30);
    checkDecision(1'b0, 0, 1'b0, 1'b0);
    applyStimulus(100, -50);
    checkDecision(1'b0, 0, 1'b0, 1'b1);
    checkOutput("slip_count_at_lock", slip_cnt, 32'd4);

    // Interleaved hits keep lock; three straight misses drop it without slipping.
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(100, -50);  checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(100, -50);  checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b1);
    applyStimulus(20, -30);   checkDecision(1'b0, 0, 1'b0, 1'b0);
    checkOutput("slip_count_after_loss", slip_cnt, 32'd4);

    // Re-dwell at phase 0 fails and slips to phase 1, then reset mid-dwell.
    repeat (4) applyStimulus(20, -30);
    checkDecision(1'b1, 1, 1'b0, 1'b0);
    applyStimulus(20, -30);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    #1;
    checkOutput("clr_accclr", 32'(accclr), 32'd0);
    checkOutput("clr_dv", 32'(dump_valid), 32'd0);
    checkOutput("clr_mag", 32'(mag), 32'd0);
    checkOutput("clr_slip", 32'(slip_req), 32'd0);
    checkOutput("clr_phase", 32'(code_phase), 32'd0);
    checkOutput("clr_lock", 32'(acq_lock), 32'd0);
    checkOutput("clr_sf", 32'(search_fail), 32'd0);
    repeat (3) @(negedge clk);

    // Enable drops on the cycle whose edge would be the epoch boundary.
    clr = 1'b1;
    have_ref = 0;
    repeat (8) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checkOutput("boundary_dv", 32'(dump_valid), 32'd0);
    checkOutput("boundary_accclr", 32'(accclr), 32'd1);
    checkOutput("boundary_slip", 32'(slip_req), 32'd0);
    checkOutput("boundary_lock", 32'(acq_lock), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("boundary_dv_late", 32'(dump_valid), 32'd0);

    // Enable drops right after a capture: the pending dump is discarded.
    en = 1'b1;
    ref_cyc = cyc + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (accclr !== 1'b1 && n < 40);
    checkOutput("discard_accclr_seen", 32'(accclr), 32'd1);
    checkOutput("discard_epoch_len", cyc - ref_cyc, 32'd8);
    en = 1'b0;
    @(negedge clk);
    checkOutput("discard_dv", 32'(dump_valid), 32'd0);
    @(negedge clk);

    // Recovery: first epoch after re-enable is a full epoch.
    en = 1'b1;
    ref_cyc = cyc + 1;
    have_ref = 1;
    applyStimulus(3, -4);
    repeat (2) @(negedge clk);
    checkOutput("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
